// File: rtl/ppm_pkg.sv
// Shared types for the pulse period meter: FSM state encoding and the
// counter-width helper used to size the period counter.
`timescale 1ns/1ps
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    COUNT      = 2'd2,
    HOLD       = 2'd3
  } ppm_state_e;

  function automatic int ppm_cnt_w(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a delay flop; emits a one-cycle rise
// strobe for each low-to-high transition of an asynchronous input.
`timescale 1ns/1ps
module sync_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of sig_in and hands
// the result out on a valid/ready pair; flags a sticky timeout when no edge arrives.
//
//   state      | meaning
//   IDLE       | waiting for start, edges ignored
//   WAIT_FIRST | armed, waiting for the first rising edge
//   COUNT      | counting cycles since the first edge
//   HOLD       | result presented, waiting for period_ready
`timescale 1ns/1ps
module pulse_period_meter
  import ppm_pkg::*;
#(
  parameter  int MAX_COUNT = 1999999,
  localparam int CNT_W     = ppm_cnt_w(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic rise;

  sync_rise_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (rise)
  );

  ppm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = WAIT_FIRST;
            cnt_d     = '0;
            timeout_d = 1'b0;
          end
        end
        WAIT_FIRST: begin
          if (rise) begin
            state_d = COUNT;
            cnt_d   = ONE_C;
          end else if (cnt_q == MAX_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        COUNT: begin
          // An edge landing on the terminal count still yields a result.
          if (rise) begin
            state_d  = HOLD;
            period_d = cnt_q;
            valid_d  = 1'b1;
          end else if (cnt_q == MAX_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        HOLD: begin
          if (valid_q && period_ready) begin
            valid_d = 1'b0;
            if (cont) begin
              state_d = WAIT_FIRST;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Measures the interval, in clk cycles, between two consecutive rising edges of an external periodic signal.
- It is the receiving end of the periodic-tick interface produced by the team's terminal-count timers: it recovers the count N from the tick stream.
- It runs single-shot or continuous. Each result is delivered on a valid/ready handshake, and a timeout flag reports when no edge arrives.
- It sits between board-level pulse inputs (or on-chip timer ticks) and the control/display logic.

Parameters:
- MAX_COUNT, 1999999, largest measurable period in clk cycles; also the timeout threshold.
- CNT_W, $clog2(MAX_COUNT+1), width of the counter and the result (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sig_in  in  1  measured signal; asynchronous to clk
- start  in  1  one-cycle pulse that arms a measurement
- abort  in  1  one-cycle pulse that cancels any activity and returns to IDLE
- cont  in  1  1 = re-arm automatically after each handshake; sampled at the handshake
- period  out  CNT_W  measured period in cycles; valid while period_valid=1
- period_valid  out  1  result available
- period_ready  in  1  consumer accepts the result
- timeout  out  1  sticky: no edge within MAX_COUNT cycles; cleared by start
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, synchroniser flops 0.
- Input path:
  - 2-FF synchroniser s1→s2, then delay flop s3.
  - rise = s2 & ~s3.
  - The fixed 2-cycle latency does not affect the measured period.
  - sig_in must hold each level for ≥2 clk; shorter pulses give undefined results.
- States: IDLE, WAIT_FIRST, COUNT, HOLD.
- IDLE:
  - start → WAIT_FIRST, counter←0, timeout←0.
  - Edges are ignored.
- WAIT_FIRST:
  - On rise → COUNT, counter←1.
  - Otherwise counter increments. On counter==MAX_COUNT with no rise → timeout←1, IDLE.
- COUNT: the counter value equals the cycles elapsed since the first edge.
  - If rise → period←counter, period_valid←1, HOLD.
  - Else if counter==MAX_COUNT → timeout←1, IDLE, period_valid stays 0.
  - Else counter←counter+1.
  - A rise exactly when counter==MAX_COUNT is a valid result: the edge wins over timeout.
- Period definition: edges detected at cycles t and t+N give period=N. Range is 1..MAX_COUNT (practically ≥4 given the input constraint).
- HOLD:
  - period and period_valid are held stable until period_valid & period_ready.
  - Edges are ignored.
  - On handshake: period_valid←0. If cont=1 → WAIT_FIRST with counter←0; else → IDLE.
  - Continuous mode therefore measures every other period, by design.
- Result timing: period_valid rises in the cycle after the second rise is detected. With ready held high, the handshake completes in that same cycle.
- abort has priority over every other event in every state: → IDLE, period_valid←0, counter←0, timeout unchanged.
- start outside IDLE is ignored.
- If start and abort are asserted together, abort wins.
- Counter never wraps: it saturates at MAX_COUNT via the timeout exit.
- rst mid-operation clears everything immediately (asynchronous); no partial result is emitted.

Decomposition:
- Shared package ppm_pkg:
  - state enum (IDLE=2'd0, WAIT_FIRST=2'd1, COUNT=2'd2, HOLD=2'd3).
  - helper function for CNT_W.
- Sub-module sync_rise_detect:
  - contains the 2-FF synchroniser plus edge flop.
  - ports clk, rst, async_in, rise.
  - reusable by other pulse inputs.
- The FSM, counter and output register stay in the top module.

Test Plan:
- Reset: assert rst mid-COUNT → all outputs 0, busy=0 in the same cycle; after release, no period_valid without start.
- Basic: MAX_COUNT=100, start, square wave with period 10 clk, ready=1 → one period_valid pulse with period=10; busy drops afterwards; timeout=0.
- Backpressure: period 17, ready held low 20 cycles → period_valid=1 and period=17 stable for all 20 cycles; single handshake; further edges do not change the value.
- Timeout/boundary: MAX_COUNT=20.
  - Edges 21 cycles apart → timeout=1, no period_valid, IDLE.
  - Edges exactly 20 apart → period=20, timeout=0.
  - Then start clears timeout.
- Abort: abort in WAIT_FIRST, in COUNT, and in HOLD with valid=1 → IDLE next cycle, period_valid=0, no result; start together with abort → stays IDLE.
- Continuous: cont=1, period 8, ready=1 → a repeating stream of period=8 results, one per two input periods; drop cont at a handshake → returns to IDLE.
